seq_muladd16: RTL and testbench

- Sequential radix-2 shift-add unit computing result = quot * divisor + rem. It is the inverse direction of the team's combinational 16-bit divider.
- It rebuilds the dividend from a quotient/remainder pair, used to check divider output and to rescale counts in the redundancy controller.
- Takes one bit of quot per clock, with valid/ready handshakes on input and output.
- One operation in flight at a time.

---
 rtl/seq_muladd16.sv | 142 ++++++++++++++
 tb/tb_seq_muladd16.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muladd16.sv
// seq_muladd16: sequential radix-2 shift-add unit computing result = quot * divisor + rem.
// Rebuilds a dividend from a quotient/remainder pair, one quotient bit per clock.
// Only one operation is in flight at a time.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_i      asynchronous active-high reset
//   in_valid_i   operands present
//   in_ready_o   unit can accept operands (IDLE)
//   quot_i       multiplier (quotient), WIDTH bits
//   divisor_i    multiplicand, WIDTH bits
//   rem_i        addend (remainder), WIDTH bits
//   out_valid_o  result present (DONE)
//   out_ready_i  consumer accepts result
//   result_o     quot*divisor + rem, 2*WIDTH bits, unsigned and exact
//   ovf_o        upper half of result nonzero
//   rem_err_o    rem >= divisor (includes divisor == 0)
//
// Optional build macro SEQ_MULADD_EARLY_TERM_EN: BUSY also exits as soon as the shifted
// multiplier becomes zero, so latency tracks the highest set bit of quot. Without it the
// latency is always WIDTH edges and no early-exit logic exists.
module seq_muladd16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   quot_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic [WIDTH-1:0]   rem_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ovf_o,
  output logic               rem_err_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ovf_q, ovf_d;
  // rem_err is captured at accept but only published on completion, so the visible
  // rem_err always belongs to the same operation as the visible result.
  logic               rem_err_pend_q, rem_err_pend_d;
  logic               rem_err_q, rem_err_d;

  logic [2*WIDTH-1:0] acc_sum;
  logic               last;

  always_comb begin
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last    = (cnt_q == CntW'(WIDTH - 1));
`ifdef SEQ_MULADD_EARLY_TERM_EN
    // Shifted multiplier is zero: no further partial products can contribute.
    last    = last | (mplier_q[WIDTH-1:1] == '0);
`endif
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    ovf_d          = ovf_q;
    rem_err_pend_d = rem_err_pend_q;
    rem_err_d      = rem_err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          acc_d          = {{WIDTH{1'b0}}, rem_i};
          mcand_d        = {{WIDTH{1'b0}}, divisor_i};
          mplier_d       = quot_i;
          cnt_d          = '0;
          rem_err_pend_d = (rem_i >= divisor_i);
          state_d        = StBusy;
        end
      end
      StBusy: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last) begin
          state_d   = StDone;
          result_d  = acc_sum;
          ovf_d     = |acc_sum[2*WIDTH-1:WIDTH];
          rem_err_d = rem_err_pend_q;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      ovf_q          <= 1'b0;
      rem_err_pend_q <= 1'b0;
      rem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      ovf_q          <= ovf_d;
      rem_err_pend_q <= rem_err_pend_d;
      rem_err_q      <= rem_err_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign result_o    = result_q;
  assign ovf_o       = ovf_q;
  assign rem_err_o   = rem_err_q;

endmodule

// File: tb/tb_seq_muladd16.sv
// Scoreboard bench for seq_muladd16: the driver pushes expected responses computed with
// plain arithmetic; a negedge monitor checks every presented result against the queue head.
module tb_seq_muladd16;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] quot_i = '0, divisor_i = '0, rem_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o;
  logic        ovf_o, rem_err_o;

  seq_muladd16 #(.WIDTH(16)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .quot_i     (quot_i),
    .divisor_i  (divisor_i),
    .rem_i      (rem_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .ovf_o      (ovf_o),
    .rem_err_o  (rem_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        rerr;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   or_mode = 0;  // 0: out_ready high, 1: random, 2: held low

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    #2;
    case (or_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ($urandom_range(0, 2) != 0);
      default: out_ready_i = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] q, input logic [15:0] d,
                                 input logic [15:0] r, input int ac);
    exp_t        e;
    int unsigned a, b, c;
    a = q;
    b = d;
    c = r;
    e.res     = a * b + c;
    e.ovf     = (e.res >> 16) != 0;
    e.rerr    = (r >= d);
    e.acc_cyc = ac;
`ifdef SEQ_MULADD_EARLY_TERM_EN
    e.lat = 1;
    for (int i = 0; i < 16; i++) if (q[i]) e.lat = i + 1;
`else
    e.lat = 16;
`endif
    return e;
  endfunction

  // Monitor
  bit seen = 0;
  bit ready_next = 0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      seen       = 0;
      ready_next = 0;
    end else begin
      if (ready_next) begin
        chk("in_ready_after_handshake", {31'b0, in_ready_o}, 32'd1);
        ready_next = 0;
      end
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", {31'b0, out_valid_o}, 32'd0);
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
          end
          chk("result", result_o, sb[0].res);
          chk("ovf", {31'b0, ovf_o}, {31'b0, sb[0].ovf});
          chk("rem_err", {31'b0, rem_err_o}, {31'b0, sb[0].rerr});
          chk("in_ready_in_done", {31'b0, in_ready_o}, 32'd0);
          if (out_ready_i) begin
            void'(sb.pop_front());
            seen       = 0;
            ready_next = 1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r);
    bit ok;
    ok = 0;
    @(posedge clk_i);
    #2;
    in_valid_i = 1'b1;
    quot_i     = q;
    divisor_i  = d;
    rem_i      = r;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back(model(q, d, r, cyc + 1));
    end
    @(posedge clk_i);
    #2;
    in_valid_i = 1'b0;
    // Scramble operand pins: they must be ignored after the accepting edge.
    quot_i     = 16'($urandom);
    divisor_i  = 16'($urandom);
    rem_i      = 16'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && in_ready_o) return;
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_out_valid"}, {31'b0, out_valid_o}, 32'd0);
    chk({nm, "_in_ready"}, {31'b0, in_ready_o}, 32'd1);
    chk({nm, "_result"}, result_o, 32'd0);
    chk({nm, "_ovf"}, {31'b0, ovf_o}, 32'd0);
    chk({nm, "_rem_err"}, {31'b0, rem_err_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q, d, r;
    bit ok;

    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;

    // Directed cases
    issue(16'd7, 16'd3, 16'd2);              wait_idle();
    issue(16'hFFFF, 16'hFFFF, 16'hFFFE);     wait_idle();
    issue(16'hFFFF, 16'hFFFF, 16'hFFFF);     wait_idle();
    issue(16'd5, 16'd0, 16'd9);              wait_idle();
    issue(16'd0, 16'h1234, 16'h0055);        wait_idle();
    issue(16'd1, 16'd7, 16'd0);              wait_idle();
    issue(16'h8000, 16'd2, 16'd0);           wait_idle();

    // Back-pressure with ignored in_valid pulses during BUSY/DONE
    or_mode = 2;
    issue(16'h1234, 16'h0010, 16'h000F);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #2;
      in_valid_i = i[0];
      quot_i     = 16'($urandom);
      divisor_i  = 16'($urandom);
      rem_i      = 16'($urandom);
    end
    @(posedge clk_i);
    #2;
    in_valid_i = 1'b0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (out_valid_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("bp_valid_timeout", 32'd0, 32'd1);
    repeat (5) @(posedge clk_i);
    or_mode = 0;
    wait_idle();

    // Reset 8 edges into BUSY aborts the operation
    issue(16'h4321, 16'h0077, 16'h0003);
    repeat (8) @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    chk_reset_outputs("abort");
    sb.delete();
    repeat (2) @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    repeat (30) @(negedge clk_i);  // monitor flags any stray out_valid
    issue(16'd2, 16'd2, 16'd1);
    wait_idle();

    // Randomized back-to-back traffic with random back-pressure
    or_mode = 1;
    for (int n = 0; n < 40; n++) begin
      q = 16'($urandom);
      d = 16'($urandom);
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) q = q >> $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) r = (d == 0) ? r : 16'(r % d);
      issue(q, d, r);
    end
    wait_idle();
    or_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
